// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared constants and encodings for the simple RISC CPU datapath:
//   DW / PCW      data and program-counter widths
//   alu_op_e      ALU function encodings
//   shift_e       B-path shifter encodings
//   VS_*          bit positions inside the one-hot write-back select (vsel)
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int DW  = 16;
  localparam int PCW = 9;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_MVN = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_e;

  localparam int VS_MDATA = 3;
  localparam int VS_IMM8  = 2;
  localparam int VS_PC    = 1;
  localparam int VS_C     = 0;

endpackage : cpu_pkg

// File: rtl/dp_regfile.sv
// -----------------------------------------------------------------------------
// dp_regfile
// 8 x DW register file: synchronous write, asynchronous (combinational) read,
// asynchronous active-low clear. A read of the entry being written in the same
// cycle returns the old contents (no write-to-read bypass).
// Ports:
//   i_clk      rising-edge clock
//   i_rst_n    asynchronous active-low clear of all entries
//   i_we       write enable
//   i_wr_idx   write index
//   i_wr_data  write data
//   i_rd_idx   read index
//   o_rd_data  read data, R[i_rd_idx]
// -----------------------------------------------------------------------------
module dp_regfile #(
  parameter int DW   = 16,
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_wr_idx,
  input  logic [DW-1:0] i_wr_data,
  input  logic [AW-1:0] i_rd_idx,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] r_regs [NREG];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      r_regs[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data = r_regs[i_rd_idx];

endmodule : dp_regfile

// File: rtl/cpu_datapath.sv
// -----------------------------------------------------------------------------
// cpu_datapath
// 16-bit execution datapath of the simple RISC CPU: register file, A/B operand
// registers, B-path shifter, operand muxes, 4-function ALU, result register C
// and Z/N/V status flags. All sequencing comes from the external controller.
//
// Optional feature macro: DP_VFLAG_EN
//   defined   : signed-overflow flag computed and held in a V register
//   undefined : no V register or overflow logic, V_out tied to 0
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset, clears all state
//   readnum      register-file read index
//   writenum     register-file write index
//   write        register-file write enable
//   vsel         one-hot write-back select (3 mdata, 2 sximm8, 1 PC, 0 C)
//   loada/loadb  load A / B from the register-file read port
//   shift        B shifter operation
//   asel         1: A operand forced to 0
//   bsel         1: B operand is sximm5
//   ALUop        ALU function
//   loadc        load C from ALU result
//   loads        load Z/N/V from ALU result
//   sximm8       sign-extended 8-bit immediate
//   sximm5       sign-extended 5-bit immediate
//   PC           program counter
//   mdata        memory read data
//   Z_out/N_out/V_out  status flags
//   datapath_out contents of C
// -----------------------------------------------------------------------------
module cpu_datapath
  import cpu_pkg::*;
#(
  parameter int DW  = cpu_pkg::DW,
  parameter int PCW = cpu_pkg::PCW
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [2:0]     readnum,
  input  logic [2:0]     writenum,
  input  logic           write,
  input  logic [3:0]     vsel,
  input  logic           loada,
  input  logic           loadb,
  input  logic [1:0]     shift,
  input  logic           asel,
  input  logic           bsel,
  input  logic [1:0]     ALUop,
  input  logic           loadc,
  input  logic           loads,
  input  logic [DW-1:0]  sximm8,
  input  logic [DW-1:0]  sximm5,
  input  logic [PCW-1:0] PC,
  input  logic [DW-1:0]  mdata,
  output logic           Z_out,
  output logic           N_out,
  output logic           V_out,
  output logic [DW-1:0]  datapath_out
);

  logic [DW-1:0]        w_wb_data;
  logic [DW-1:0]        w_rd_data;
  logic signed [DW-1:0] r_a;
  logic signed [DW-1:0] r_b;
  logic signed [DW-1:0] r_c;
  logic                 r_z;
  logic                 r_n;
  logic signed [DW-1:0] w_b_sh;
  logic signed [DW-1:0] w_ain;
  logic signed [DW-1:0] w_bin;
  logic signed [DW-1:0] w_alu;

  // Write-back source: highest set vsel bit wins, nothing selected writes 0.
  always_comb begin
    w_wb_data = '0;
    if (vsel[VS_MDATA])     w_wb_data = mdata;
    else if (vsel[VS_IMM8]) w_wb_data = sximm8;
    else if (vsel[VS_PC])   w_wb_data = {{(DW-PCW){1'b0}}, PC};
    else if (vsel[VS_C])    w_wb_data = r_c;
  end

  dp_regfile #(
    .DW   (DW),
    .NREG (8),
    .AW   (3)
  ) u_rf (
    .i_clk     (clk),
    .i_rst_n   (reset),
    .i_we      (write),
    .i_wr_idx  (writenum),
    .i_wr_data (w_wb_data),
    .i_rd_idx  (readnum),
    .o_rd_data (w_rd_data)
  );

  // ---- operand register stage ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a <= '0;
      r_b <= '0;
    end else begin
      if (loada) r_a <= w_rd_data;
      if (loadb) r_b <= w_rd_data;
    end
  end

  always_comb begin
    w_b_sh = r_b;
    case (shift)
      SH_LSL:  w_b_sh = r_b <<< 1;
      SH_LSR:  w_b_sh = r_b >> 1;
      SH_ASR:  w_b_sh = r_b >>> 1;
      default: w_b_sh = r_b;
    endcase
  end

  assign w_ain = asel ? '0 : r_a;
  assign w_bin = bsel ? sximm5 : w_b_sh;

  always_comb begin
    w_alu = '0;
    case (ALUop)
      ALU_ADD: w_alu = w_ain + w_bin;
      ALU_SUB: w_alu = w_ain - w_bin;
      ALU_AND: w_alu = w_ain & w_bin;
      default: w_alu = ~w_bin;
    endcase
  end

  // ---- result / status stage ----
  // Flags are taken from the live ALU result, so a compare (loads without
  // loadc) updates them while C keeps its previous value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_c <= '0;
      r_z <= 1'b0;
      r_n <= 1'b0;
    end else begin
      if (loadc) r_c <= w_alu;
      if (loads) begin
        r_z <= (w_alu == '0);
        r_n <= w_alu[DW-1];
      end
    end
  end

`ifdef DP_VFLAG_EN
  logic r_v;

  // Signed overflow from operand and result sign bits only; logical ops never
  // overflow.
  function automatic logic f_overflow(input logic [1:0] op, input logic sa,
                                      input logic sb, input logic sr);
    logic ov;
    ov = 1'b0;
    case (op)
      ALU_ADD: ov = (sa == sb) && (sr != sa);
      ALU_SUB: ov = (sa != sb) && (sr != sa);
      default: ov = 1'b0;
    endcase
    return ov;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v <= 1'b0;
    end else if (loads) begin
      r_v <= f_overflow(ALUop, w_ain[DW-1], w_bin[DW-1], w_alu[DW-1]);
    end
  end

  assign V_out = r_v;
`else
  assign V_out = 1'b0;
`endif

  assign Z_out        = r_z;
  assign N_out        = r_n;
  assign datapath_out = r_c;

endmodule : cpu_datapath

// File: tb/tb_cpu_datapath.sv
// -----------------------------------------------------------------------------
// tb_cpu_datapath
// Self-checking bench for cpu_datapath. Expected results are queued as each
// operation is driven and compared once the clock edge has produced them.
// Build with +define+DP_VFLAG_EN to expect live overflow flags.
// -----------------------------------------------------------------------------
module tb_cpu_datapath;
  import cpu_pkg::*;

`ifdef DP_VFLAG_EN
  localparam bit VEN = 1'b1;
`else
  localparam bit VEN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic [3:0]  vsel;
  logic        loada;
  logic        loadb;
  logic [1:0]  shift;
  logic        asel;
  logic        bsel;
  logic [1:0]  ALUop;
  logic        loadc;
  logic        loads;
  logic [15:0] sximm8;
  logic [15:0] sximm5;
  logic [8:0]  PC;
  logic [15:0] mdata;
  logic        Z_out;
  logic        N_out;
  logic        V_out;
  logic [15:0] datapath_out;

  cpu_datapath dut (
    .clk          (clk),
    .reset        (reset),
    .readnum      (readnum),
    .writenum     (writenum),
    .write        (write),
    .vsel         (vsel),
    .loada        (loada),
    .loadb        (loadb),
    .shift        (shift),
    .asel         (asel),
    .bsel         (bsel),
    .ALUop        (ALUop),
    .loadc        (loadc),
    .loads        (loads),
    .sximm8       (sximm8),
    .sximm5       (sximm5),
    .PC           (PC),
    .mdata        (mdata),
    .Z_out        (Z_out),
    .N_out        (N_out),
    .V_out        (V_out),
    .datapath_out (datapath_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [15:0] c;
    logic        z;
    logic        n;
    logic        v;
    bit          flg;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  // Reference behaviour for one ALU operation on raw operands.
  function automatic exp_t model(string nm, logic [1:0] op, logic [15:0] a, logic [15:0] b);
    exp_t r;
    int   sa;
    int   sbv;
    int   s;
    r.nm  = nm;
    r.flg = 1'b1;
    r.v   = 1'b0;
    sa    = $signed(a);
    sbv   = $signed(b);
    case (op)
      2'd0: begin s = sa + sbv; r.c = a + b; r.v = (s > 32767) || (s < -32768); end
      2'd1: begin s = sa - sbv; r.c = a - b; r.v = (s > 32767) || (s < -32768); end
      2'd2: r.c = a & b;
      default: r.c = ~b;
    endcase
    r.z = (r.c == 16'h0000);
    r.n = r.c[15];
    r.v = r.v & VEN;
    return r;
  endfunction

  function automatic exp_t mk(string nm, logic [15:0] c, bit flg, logic z, logic n, logic v);
    exp_t r;
    r.nm = nm; r.c = c; r.flg = flg; r.z = z; r.n = n; r.v = v;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write = 0; loada = 0; loadb = 0; loadc = 0; loads = 0;
    vsel = 4'b0000; asel = 0; bsel = 0; shift = 2'b00; ALUop = 2'b00;
  endtask

  task automatic wr_imm(input logic [2:0] n, input logic [15:0] v);
    idle();
    writenum = n; vsel = 4'b0100; sximm8 = v; write = 1;
    tick();
    idle();
  endtask

  task automatic ld_a(input logic [2:0] n);
    idle(); readnum = n; loada = 1; tick(); idle();
  endtask

  task automatic ld_b(input logic [2:0] n);
    idle(); readnum = n; loadb = 1; tick(); idle();
  endtask

  // Copies Rn into C through A (B path bypassed with a zero immediate).
  task automatic rd_to_c(input logic [2:0] n);
    ld_a(n);
    asel = 0; bsel = 1; sximm5 = 16'h0000; ALUop = ALU_ADD; loadc = 1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (datapath_out !== 16'h0000) begin
      errors++; $display("FAIL reset_c: datapath_out=%h expected 0000", datapath_out);
    end
    checks++;
    if ({Z_out, N_out, V_out} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: ZNV=%b expected 000", {Z_out, N_out, V_out});
    end
    reset = 1;
    tick();
    wr_imm(3, 16'h1234);
    sb.push_back(mk("pre_reset_r3", 16'h1234, 0, 0, 0, 0));
    rd_to_c(3);
    e = sb.pop_front(); checks++;
    if (datapath_out !== e.c) begin
      errors++; $display("FAIL %s: datapath_out=%h expected %h", e.nm, datapath_out, e.c);
    end
    // MVN of zero immediate sets N without touching C.
    asel = 1; bsel = 1; sximm5 = 16'h0000; ALUop = ALU_MVN; loads = 1;
    sb.push_back(mk("pre_reset_flags", 16'h1234, 1, 0, 1, 0));
    tick();
    idle();
    e = sb.pop_front(); checks++;
    if (datapath_out !== e.c) begin
      errors++; $display("FAIL %s: datapath_out=%h expected %h", e.nm, datapath_out, e.c);
    end
    checks++;
    if ({Z_out, N_out, V_out} !== {e.z, e.n, e.v}) begin
      errors++; $display("FAIL %s: ZNV=%b expected %b", e.nm, {Z_out, N_out, V_out}, {e.z, e.n, e.v});
    end
    #2 reset = 0;
    #1;
    checks++;
    if (datapath_out !== 16'h0000) begin
      errors++; $display("FAIL async_reset_c: datapath_out=%h expected 0000", datapath_out);
    end
    checks++;
    if ({Z_out, N_out, V_out} !== 3'b000) begin
      errors++; $display("FAIL async_reset_flags: ZNV=%b expected 000", {Z_out, N_out, V_out});
    end
    #3 reset = 1;
    tick();
    sximm5 = 16'h0000;
    sb.push_back(mk("async_reset_r3", 16'h0000, 0, 0, 0, 0));
    rd_to_c(3);
    e = sb.pop_front(); checks++;
    if (datapath_out !== e.c) begin
      errors++; $display("FAIL %s: datapath_out=%h expected %h", e.nm, datapath_out, e.c);
    end
  endtask

  task automatic test_mov_add();
    wr_imm(0, 16'd7);
    wr_imm(1, 16'd2);
    ld_a(0);
    ld_b(1);
    shift = SH_LSL; ALUop = ALU_ADD; loadc = 1; loads = 1;
    sb.push_back(mk("add_lsl", 16'd11, 1, 0, 0, 0));
    tick();
    idle();
    e = sb.pop_front(); checks++;
    if (datapath_out !== e.c) begin
      errors++; $display("FAIL %s: datapath_out=%h expected %h", e.nm, datapath_out, e.c);
    end
    checks++;
    if ({Z_out, N_out, V_out} !== {e.z, e.n, e.v}) begin
      errors++; $display("FAIL %s: ZNV=%b expected %b", e.nm, {Z_out, N_out, V_out}, {e.z, e.n, e.v});
    end
    writenum = 2; vsel = 4'b0001; write = 1;
    tick();
    idle();
    sb.push_back(mk("wb_c_r2", 16'd11, 0, 0, 0, 0));
    rd_to_c(2);
    e = sb.pop_front(); checks++;
    if (datapath_out !== e.c) begin
      errors++; $display("FAIL %s: datapath_out=%h expected %h", e.nm, datapath_out, e.c);
    end
  endtask

  task automatic test_sub_ovf();
    wr_imm(4, 16'h8000);
    wr_imm(5, 16'h0001);
    ld_a(4);
    ld_b(5);
    ALUop = ALU_SUB; loadc = 1; loads = 1;
    sb.push_back(mk("sub_ovf", 16'h7FFF, 1, 0, 0, VEN));
    tick();
    idle();
    e = sb.pop_front(); checks++;
    if (datapath_out !== e.c) begin
      errors++; $display("FAIL %s: datapath_out=%h expected %h", e.nm, datapath_out, e.c);
    end
    checks++;
    if ({Z_out, N_out, V_out} !== {e.z, e.n, e.v}) begin
      errors++; $display("FAIL %s: ZNV=%b expected %b", e.nm, {Z_out, N_out, V_out}, {e.z, e.n, e.v});
    end
  endtask

  task automatic test_cmp();
    wr_imm(6, 16'h00F0);
    readnum = 6; loada = 1; loadb = 1;
    tick();
    idle();
    ALUop = ALU_SUB; loads = 1;
    sb.push_back(mk("cmp_equal", 16'h7FFF, 1, 1, 0, 0));
    tick();
    idle();
    e = sb.pop_front(); checks++;
    if (datapath_out !== e.c) begin
      errors++; $display("FAIL %s: datapath_out=%h expected %h", e.nm, datapath_out, e.c);
    end
    checks++;
    if ({Z_out, N_out, V_out} !== {e.z, e.n, e.v}) begin
      errors++; $display("FAIL %s: ZNV=%b expected %b", e.nm, {Z_out, N_out, V_out}, {e.z, e.n, e.v});
    end
  endtask

  task automatic test_shift_mvn();
    logic [1:0]  sh_tab [4];
    logic [15:0] c_tab  [4];
    sh_tab = '{SH_ASR, SH_LSR, SH_LSL, SH_NONE};
    c_tab  = '{16'h3FFE, 16'hBFFE, 16'hFFFB, 16'h7FFD};
    wr_imm(7, 16'h8002);
    ld_b(7);
    for (int i = 0; i < 4; i++) begin
      asel = 1; shift = sh_tab[i]; ALUop = ALU_MVN; loadc = 1; loads = 1;
      sb.push_back(mk($sformatf("mvn_shift%0d", sh_tab[i]), c_tab[i], 1, 0, c_tab[i][15], 0));
      tick();
      idle();
      e = sb.pop_front(); checks++;
      if (datapath_out !== e.c) begin
        errors++; $display("FAIL %s: datapath_out=%h expected %h", e.nm, datapath_out, e.c);
      end
      checks++;
      if ({Z_out, N_out, V_out} !== {e.z, e.n, e.v}) begin
        errors++; $display("FAIL %s: ZNV=%b expected %b", e.nm, {Z_out, N_out, V_out}, {e.z, e.n, e.v});
      end
    end
  endtask

  task automatic test_writeback();
    logic [3:0]  vs_tab [6];
    logic [15:0] wb_tab [6];
    vs_tab = '{4'b1000, 4'b0000, 4'b0010, 4'b1111, 4'b0110, 4'b0011};
    wb_tab = '{16'hBEEF, 16'h0000, 16'h01FF, 16'hBEEF, 16'h1357, 16'h01FF};
    for (int i = 0; i < 6; i++) begin
      idle();
      mdata = 16'hBEEF; sximm8 = 16'h1357; PC = 9'h1FF;
      vsel = vs_tab[i]; writenum = 1; write = 1;
      tick();
      idle();
      sb.push_back(mk($sformatf("wb_vsel_%b", vs_tab[i]), wb_tab[i], 0, 0, 0, 0));
      rd_to_c(1);
      e = sb.pop_front(); checks++;
      if (datapath_out !== e.c) begin
        errors++; $display("FAIL %s: datapath_out=%h expected %h", e.nm, datapath_out, e.c);
      end
    end
    // R5 holds 0001; write ABCD while reading R5 into A in the same cycle.
    writenum = 5; vsel = 4'b0100; sximm8 = 16'hABCD; write = 1; readnum = 5; loada = 1;
    tick();
    idle();
    asel = 0; bsel = 1; sximm5 = 16'h0000; ALUop = ALU_ADD; loadc = 1;
    sb.push_back(mk("same_cycle_old", 16'h0001, 0, 0, 0, 0));
    tick();
    idle();
    e = sb.pop_front(); checks++;
    if (datapath_out !== e.c) begin
      errors++; $display("FAIL %s: datapath_out=%h expected %h", e.nm, datapath_out, e.c);
    end
    sb.push_back(mk("same_cycle_new", 16'hABCD, 0, 0, 0, 0));
    rd_to_c(5);
    e = sb.pop_front(); checks++;
    if (datapath_out !== e.c) begin
      errors++; $display("FAIL %s: datapath_out=%h expected %h", e.nm, datapath_out, e.c);
    end
  endtask

  task automatic test_hold();
    asel = 1; bsel = 1; sximm5 = 16'h0000; ALUop = ALU_MVN; loadc = 1; loads = 1;
    tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      readnum = 3'($urandom_range(0, 7)); writenum = 3'($urandom_range(0, 7));
      sximm8 = 16'($urandom); sximm5 = 16'($urandom); mdata = 16'($urandom);
      vsel = 4'($urandom_range(0, 15)); shift = 2'($urandom_range(0, 3));
      ALUop = 2'($urandom_range(0, 3)); asel = 1'($urandom_range(0, 1)); bsel = 1'($urandom_range(0, 1));
      sb.push_back(mk($sformatf("hold_%0d", i), 16'hFFFF, 1, 0, 1, 0));
      tick();
      e = sb.pop_front(); checks++;
      if (datapath_out !== e.c) begin
        errors++; $display("FAIL %s: datapath_out=%h expected %h", e.nm, datapath_out, e.c);
      end
      checks++;
      if ({Z_out, N_out, V_out} !== {e.z, e.n, e.v}) begin
        errors++; $display("FAIL %s: ZNV=%b expected %b", e.nm, {Z_out, N_out, V_out}, {e.z, e.n, e.v});
      end
    end
    idle();
    sb.push_back(mk("hold_r5", 16'hABCD, 0, 0, 0, 0));
    rd_to_c(5);
    e = sb.pop_front(); checks++;
    if (datapath_out !== e.c) begin
      errors++; $display("FAIL %s: datapath_out=%h expected %h", e.nm, datapath_out, e.c);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a_tab [6];
    logic [15:0] b_tab [6];
    a_tab = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h1234, 16'h0000, 16'h0000};
    b_tab = '{16'h0001, 16'h8000, 16'h0001, 16'h1234, 16'h0000, 16'h0000};
    a_tab[5] = 16'($urandom);
    b_tab[5] = 16'($urandom);
    for (int i = 0; i < 6; i++) begin
      wr_imm(0, a_tab[i]);
      wr_imm(1, b_tab[i]);
      ld_a(0);
      ld_b(1);
      for (int op = 0; op < 4; op++) begin
        ALUop = 2'(op); loadc = 1; loads = 1;
        sb.push_back(model($sformatf("b2b_%0d_op%0d", i, op), 2'(op), a_tab[i], b_tab[i]));
        tick();
        e = sb.pop_front(); checks++;
        if (datapath_out !== e.c) begin
          errors++; $display("FAIL %s: datapath_out=%h expected %h", e.nm, datapath_out, e.c);
        end
        checks++;
        if ({Z_out, N_out, V_out} !== {e.z, e.n, e.v}) begin
          errors++; $display("FAIL %s: ZNV=%b expected %b", e.nm, {Z_out, N_out, V_out}, {e.z, e.n, e.v});
        end
      end
      idle();
    end
  endtask

  initial begin
    reset = 0;
    readnum = 0; writenum = 0;
    sximm8 = 0; sximm5 = 0; PC = 0; mdata = 0;
    idle();
    test_reset();
    test_mov_add();
    test_sub_ovf();
    test_cmp();
    test_shift_mvn();
    test_writeback();
    test_hold();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule : tb_cpu_datapath

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- 16-bit execution datapath of the simple RISC CPU.
- Contains an 8×16 register file, A/B operand registers, a B-path shifter, source muxes, a 4-function ALU, result register C, and Z/N/V status flags.
- Fully controlled by the fsm (load enables, selects) and ins_decoder (register numbers, shift, ALUop, immediates).
- datapath_out feeds memory write data and the data-address register.

Parameters:
- DW, 16, data width of registers, ALU and result path.
- PCW, 9, program-counter width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low; clears all state.
- readnum  input  3  register-file read index.
- writenum  input  3  register-file write index.
- write  input  1  register-file write enable.
- vsel  input  4  one-hot write-back source select: bit3 mdata, bit2 sximm8, bit1 PC, bit0 datapath_out.
- loada  input  1  load A register from read port.
- loadb  input  1  load B register from read port.
- shift  input  2  B shifter op.
- asel  input  1  1 = A operand forced to 0.
- bsel  input  1  1 = B operand is sximm5.
- ALUop  input  2  ALU function.
- loadc  input  1  load C from ALU result.
- loads  input  1  load status flags.
- sximm8  input  16  sign-extended 8-bit immediate.
- sximm5  input  16  sign-extended 5-bit immediate.
- PC  input  9  program counter.
- mdata  input  16  memory read data.
- Z_out  output  1  zero flag.
- N_out  output  1  negative flag.
- V_out  output  1  overflow flag.
- datapath_out  output  16  contents of C.

Behaviour:
- Reset (reset=0, async): R0–R7, A, B, C, Z/N/V all 0. datapath_out=0, flags=0. Reset dominates all enables.
- Write-back data (combinational):
  - vsel priority: bit3 mdata > bit2 sximm8 > bit1 {7'b0,PC} > bit0 C.
  - vsel==0 gives 0.
- Register file:
  - On posedge clk with write=1, R[writenum] <= write-back data.
  - Read is combinational, R[readnum].
  - Read of the register being written in the same cycle returns the old value; no bypass.
- A/B registers: on posedge, A <= R[readnum] if loada; B <= R[readnum] if loadb. Both may load the same cycle.
- Shifter on B:
  - 00: pass.
  - 01: left 1, LSB=0.
  - 10: logical right 1, MSB=0.
  - 11: arithmetic right 1, MSB replicated.
- Operands: Ain = asel ? 0 : A. Bin = bsel ? sximm5 : shifted B.
- ALU (16-bit, wrap-around, no carry out):
  - 00: Ain+Bin.
  - 01: Ain−Bin.
  - 10: Ain&Bin.
  - 11: ~Bin.
- C: on posedge, C <= ALU result if loadc.
- Status: on posedge, if loads:
  - Z <= (result==0).
  - N <= result[15].
  - V <= signed overflow. ADD: operands same sign and result sign differs. SUB: operands differ in sign and result sign differs from Ain. 0 for AND/MVN.
- Flags come from the live ALU result in the same cycle as loadc, not from C.
- Latency:
  - Register read to C: 2 edges (loada/loadb, then loadc).
  - C to register file: 1 edge.
- Hold rule: all enables low means every register holds its value.

Optional Feature:
- DP_VFLAG_EN.
  - Defined: V_out computed and loaded as above.
  - Undefined: V register and overflow logic omitted; V_out tied 0. Z/N unaffected.

Decomposition:
- Shared package cpu_pkg:
  - ALUop encodings (ALU_ADD, ALU_SUB, ALU_AND, ALU_MVN).
  - Shift encodings (SH_NONE, SH_LSL, SH_LSR, SH_ASR).
  - vsel bit indices (VS_MDATA=3, VS_IMM8=2, VS_PC=1, VS_C=0).
  - DW/PCW constants.
- One natural sub-module: dp_regfile (8×16, sync write, async read, async active-low clear).
- ALU and shifter stay inline.

Test Plan:
- Reset mid-run: load R3=16'h1234, assert reset=0 asynchronously between edges → R3, C, flags read 0 immediately; datapath_out=0.
- MOV imm then ADD:
  - R0<=sximm8=7, R1<=sximm8=2 (vsel=0100).
  - A<=R0, B<=R1, shift=01, ALUop=00, loadc → datapath_out=16'd11.
  - Write-back vsel=0001 to R2 → R2=11.
- SUB overflow: A=16'h8000, B=1, ALUop=01, loads → C=16'h7FFF; Z=0, N=0, V=1 (V=0 when DP_VFLAG_EN undefined).
- CMP equal: A=B=16'h00F0, ALUop=01, loads=1, loadc=0 → Z=1, N=0, V=0; C unchanged.
- Shifter/MVN:
  - B=16'h8002, shift=11, ALUop=11, asel=1 → C=~16'hC001=16'h3FFE.
  - shift=10 → C=~16'h4001=16'hBFFE.
- Write-back sources:
  - vsel=1000 with mdata=16'hBEEF → Rn=16'hBEEF.
  - vsel=0010 with PC=9'h1FF → Rn=16'h01FF.
  - Same-cycle write/read of R5 returns old value until the next edge.
